uart_tx_arbiter: RTL and testbench

//   Shares one UART transmitter among NUM_REQ byte requesters. Round-robin arbitration

---
 rtl/uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter among NUM_REQ byte requesters.
//            Round-robin arbitration, optional bursts of up to BURST_MAX bytes
//            per grant, transmitter busy tracking and a start timeout.
//            All sequencing advances only on clk edges where clken=1.
// Ports    : clk, rst_n        clock, asynchronous active-low reset
//            clken             sequencing enable (baud domain)
//            req, req_data     level requests and packed per-requester bytes
//            ack               one-hot pulse: requester byte consumed
//            tx_start, tx_data start pulse and byte to the transmitter
//            tx_busy           transmitter busy flag
//            grant_id          current or last granted requester
//            grant_valid       high while a byte is in flight
//            timeout_err       pulse: tx_busy never rose after tx_start
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int BURST_MAX    = 1,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clken,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         tx_start,
   output logic [DATA_W-1:0]            tx_data,
   input  logic                         tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         grant_valid,
   output logic                         timeout_err
);

   localparam int c_ID_W   = $clog2(NUM_REQ);
   localparam int c_BCNT_W = $clog2(BURST_MAX + 1);
   localparam int c_TMO_W  = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [c_ID_W-1:0]   c_LAST_INIT = c_ID_W'(NUM_REQ - 1);
   localparam logic [c_BCNT_W-1:0] c_BURST_MAX = c_BCNT_W'(BURST_MAX);
   localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BUSY = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   // Registered state and outputs
   state_t                r_state;
   logic [NUM_REQ-1:0]    r_ack;
   logic                  r_tx_start;
   logic [DATA_W-1:0]     r_tx_data;
   logic [c_ID_W-1:0]     r_grant_id;
   logic                  r_grant_valid;
   logic                  r_timeout_err;
   logic [c_BCNT_W-1:0]   r_burst_cnt;
   logic [c_TMO_W-1:0]    r_tmo_cnt;
   logic [c_ID_W-1:0]     r_last_grant;

   // Next-state values
   state_t                w_state_nxt;
   logic [NUM_REQ-1:0]    w_ack_nxt;
   logic                  w_tx_start_nxt;
   logic [DATA_W-1:0]     w_tx_data_nxt;
   logic [c_ID_W-1:0]     w_grant_id_nxt;
   logic                  w_grant_valid_nxt;
   logic                  w_timeout_err_nxt;
   logic [c_BCNT_W-1:0]   w_burst_cnt_nxt;
   logic [c_TMO_W-1:0]    w_tmo_cnt_nxt;
   logic [c_ID_W-1:0]     w_last_grant_nxt;

   // Arbitration and current-grant helpers
   logic [c_ID_W-1:0]     w_pick;
   logic [NUM_REQ-1:0]    w_pick_oh;
   logic [DATA_W-1:0]     w_pick_data;
   logic [NUM_REQ-1:0]    w_cur_oh;
   logic [DATA_W-1:0]     w_cur_data;
   logic                  w_cur_req;
   int                    w_rank;
   int                    w_best_rank;

   // Round-robin pick: each requester's rank is its distance above last_grant
   // (1 .. NUM_REQ, shifted to 0-based); the lowest-ranked active request wins.
   always_comb begin
      w_pick      = '0;
      w_rank      = 0;
      w_best_rank = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_rank = i - int'(r_last_grant) - 1;
         if (w_rank < 0) begin
            w_rank = w_rank + NUM_REQ;
         end
         if (req[i] && (w_rank < w_best_rank)) begin
            w_best_rank = w_rank;
            w_pick      = c_ID_W'(i);
         end
      end
   end

   always_comb begin
      w_pick_oh   = '0;
      w_pick_data = '0;
      w_cur_oh    = '0;
      w_cur_data  = '0;
      w_cur_req   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (c_ID_W'(i) == w_pick) begin
            w_pick_oh[i] = 1'b1;
            w_pick_data  = req_data[i*DATA_W +: DATA_W];
         end
         if (c_ID_W'(i) == r_grant_id) begin
            w_cur_oh[i] = 1'b1;
            w_cur_data  = req_data[i*DATA_W +: DATA_W];
            w_cur_req   = req[i];
         end
      end
   end

   // Next-state and output logic
   always_comb begin
      w_state_nxt       = r_state;
      w_ack_nxt         = '0;
      w_tx_start_nxt    = 1'b0;
      w_timeout_err_nxt = 1'b0;
      w_tx_data_nxt     = r_tx_data;
      w_grant_id_nxt    = r_grant_id;
      w_grant_valid_nxt = r_grant_valid;
      w_burst_cnt_nxt   = r_burst_cnt;
      w_tmo_cnt_nxt     = r_tmo_cnt;
      w_last_grant_nxt  = r_last_grant;

      case (r_state)
         S_IDLE: begin
            // tx_busy is deliberately ignored while idle
            if (|req) begin
               w_ack_nxt         = w_pick_oh;
               w_tx_start_nxt    = 1'b1;
               w_tx_data_nxt     = w_pick_data;
               w_grant_id_nxt    = w_pick;
               w_grant_valid_nxt = 1'b1;
               w_burst_cnt_nxt   = c_BCNT_W'(1);
               w_tmo_cnt_nxt     = '0;
               w_state_nxt       = S_WAIT_BUSY;
            end
         end

         S_WAIT_BUSY: begin
            if (tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_tmo_cnt == c_TMO_LAST) begin
               // Transmitter never started: drop the byte, do not re-ack it
               w_timeout_err_nxt = 1'b1;
               w_last_grant_nxt  = r_grant_id;
               w_grant_valid_nxt = 1'b0;
               w_burst_cnt_nxt   = '0;
               w_state_nxt       = S_IDLE;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
            end
         end

         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (w_cur_req && (r_burst_cnt < c_BURST_MAX)) begin
                  // Burst continuation: same requester, no re-arbitration
                  w_ack_nxt       = w_cur_oh;
                  w_tx_start_nxt  = 1'b1;
                  w_tx_data_nxt   = w_cur_data;
                  w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                  w_tmo_cnt_nxt   = '0;
                  w_state_nxt     = S_WAIT_BUSY;
               end else begin
                  w_last_grant_nxt  = r_grant_id;
                  w_grant_valid_nxt = 1'b0;
                  w_burst_cnt_nxt   = '0;
                  w_state_nxt       = S_IDLE;
               end
            end
         end

         default: begin
            // Illegal encoding: return to a clean idle
            w_state_nxt       = S_IDLE;
            w_tx_data_nxt     = '0;
            w_grant_id_nxt    = '0;
            w_grant_valid_nxt = 1'b0;
            w_burst_cnt_nxt   = '0;
            w_tmo_cnt_nxt     = '0;
            w_last_grant_nxt  = c_LAST_INIT;
         end
      endcase
   end

   // State register: holds everything when clken is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_ack         <= '0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_grant_id    <= '0;
         r_grant_valid <= 1'b0;
         r_timeout_err <= 1'b0;
         r_burst_cnt   <= '0;
         r_tmo_cnt     <= '0;
         r_last_grant  <= c_LAST_INIT;
      end else if (clken) begin
         r_state       <= w_state_nxt;
         r_ack         <= w_ack_nxt;
         r_tx_start    <= w_tx_start_nxt;
         r_tx_data     <= w_tx_data_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_grant_valid <= w_grant_valid_nxt;
         r_timeout_err <= w_timeout_err_nxt;
         r_burst_cnt   <= w_burst_cnt_nxt;
         r_tmo_cnt     <= w_tmo_cnt_nxt;
         r_last_grant  <= w_last_grant_nxt;
      end
   end

   assign ack         = r_ack;
   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign grant_id    = r_grant_id;
   assign grant_valid = r_grant_valid;
   assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Two instances (burst of
//            1 and burst of 4) share stimulus; each has its own transmitter
//            model. A transaction-level reference model predicts all outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              clken = 1'b0;
   logic [N-1:0]      req      = '0;
   logic [N*DW-1:0]   req_data = '0;

   logic [N-1:0]      ack_o   [2];
   logic              start_o [2];
   logic [DW-1:0]     data_o  [2];
   logic              busy_i  [2];
   logic [1:0]        gid_o   [2];
   logic              gv_o    [2];
   logic              tmo_o   [2];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(1), .BUSY_TIMEOUT(TMO)) u_dut_b1 (
      .clk(clk), .rst_n(rst_n), .clken(clken), .req(req), .req_data(req_data),
      .ack(ack_o[0]), .tx_start(start_o[0]), .tx_data(data_o[0]), .tx_busy(busy_i[0]),
      .grant_id(gid_o[0]), .grant_valid(gv_o[0]), .timeout_err(tmo_o[0]));

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(4), .BUSY_TIMEOUT(TMO)) u_dut_b4 (
      .clk(clk), .rst_n(rst_n), .clken(clken), .req(req), .req_data(req_data),
      .ack(ack_o[1]), .tx_start(start_o[1]), .tx_data(data_o[1]), .tx_busy(busy_i[1]),
      .grant_id(gid_o[1]), .grant_valid(gv_o[1]), .timeout_err(tmo_o[1]));

   // ---------------- reference model state ----------------
   int            bmax [2] = '{1, 4};
   bit            m_fly [2];
   bit            m_started [2];
   int            m_age [2];
   int            m_sent [2];
   int            m_last [2];
   int            m_gid [2];
   logic [DW-1:0] m_data [2];
   logic [N-1:0]  m_ack [2];
   bit            m_start [2];
   bit            m_tmo [2];

   // transmitter model
   int            bcnt [2];
   bit            tx_dead = 1'b0;

   // bookkeeping
   int total = 0;
   int bad   = 0;
   int ce_cnt = 0;
   int st_run [2];
   int gq0[$];
   int gq1[$];
   int wq0[$];
   int tmo_dq[$];
   int start_edge0 = 0;
   bit tmo_prev0 = 1'b0;

   typedef struct {
      logic          ce;
      logic [N-1:0]  r;
      logic [N*DW-1:0] d;
      int            n;
      logic [N-1:0]  e_ack;
      logic          e_st;
      logic [DW-1:0] e_data;
      logic [1:0]    e_gid;
      logic          e_gv;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (r[i]) return i;
      end
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_fly[k] = 0; m_started[k] = 0; m_age[k] = 0; m_sent[k] = 0;
         m_last[k] = N - 1; m_gid[k] = 0; m_data[k] = '0;
         m_ack[k] = '0; m_start[k] = 0; m_tmo[k] = 0;
         busy_i[k] = 1'b0; bcnt[k] = 0; st_run[k] = 0;
      end
      tmo_prev0 = 1'b0;
   endtask

   task automatic issue(input int k, input int w, input logic [N*DW-1:0] d);
      m_ack[k]     = N'(1) << w;
      m_start[k]   = 1;
      m_data[k]    = d[w*DW +: DW];
      m_gid[k]     = w;
      m_fly[k]     = 1;
      m_started[k] = 0;
      m_age[k]     = 0;
   endtask

   // One clken edge of the arbitration rules, in transaction terms
   task automatic model_step(input int k, input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic b);
      m_ack[k] = '0; m_start[k] = 0; m_tmo[k] = 0;
      if (!m_fly[k]) begin
         if (r != '0) begin
            issue(k, rr_pick(r, m_last[k]), d);
            m_sent[k] = 1;
         end
      end else if (!m_started[k]) begin
         if (b) m_started[k] = 1;
         else begin
            m_age[k]++;
            if (m_age[k] == TMO) begin
               m_tmo[k] = 1; m_fly[k] = 0; m_last[k] = m_gid[k];
            end
         end
      end else if (!b) begin
         if (r[m_gid[k]] && m_sent[k] < bmax[k]) begin
            issue(k, m_gid[k], d);
            m_sent[k]++;
         end else begin
            m_fly[k] = 0; m_last[k] = m_gid[k];
         end
      end
   endtask

   // Transmitter: busy rises one clken after start, stays high 10 clkens
   task automatic tx_update(input int k, input logic st);
      if (tx_dead) begin
         busy_i[k] = 1'b0; bcnt[k] = 0;
      end else if (st && !busy_i[k]) begin
         busy_i[k] = 1'b1; bcnt[k] = 10;
      end else if (bcnt[k] > 0) begin
         bcnt[k]--;
         if (bcnt[k] == 0) busy_i[k] = 1'b0;
      end
   endtask

   // Called at a negedge with inputs set; returns at the next negedge
   task automatic step_cycle();
      logic [N-1:0]    r;
      logic [N*DW-1:0] d;
      logic            ce;
      logic            b  [2];
      logic            st [2];
      r = req; d = req_data; ce = clken;
      for (int k = 0; k < 2; k++) begin b[k] = busy_i[k]; st[k] = start_o[k]; end
      @(posedge clk);
      #1;
      if (ce) begin
         ce_cnt++;
         for (int k = 0; k < 2; k++) begin
            model_step(k, r, d, b[k]);
            tx_update(k, st[k]);
         end
      end
      for (int k = 0; k < 2; k++) begin
         check(k == 0 ? "outputs_b1" : "outputs_b4",
               {15'd0, ack_o[k], start_o[k], data_o[k], gid_o[k], gv_o[k], tmo_o[k]},
               {15'd0, m_ack[k], m_start[k], m_data[k], m_gid[k][1:0], m_fly[k], m_tmo[k]});
         if (start_o[k]) begin
            st_run[k]++;
            if (st_run[k] == 1) begin
               if (k == 0) begin gq0.push_back(int'(gid_o[0])); start_edge0 = ce_cnt; end
               else gq1.push_back(int'(gid_o[1]));
            end
         end else begin
            if (k == 0 && st_run[0] > 0) wq0.push_back(st_run[0]);
            st_run[k] = 0;
         end
      end
      if (tmo_o[0] && !tmo_prev0) tmo_dq.push_back(ce_cnt - start_edge0);
      tmo_prev0 = tmo_o[0];
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; req = '0; clken = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int n);
      req = '0; clken = 1'b1;
      repeat (n) step_cycle();
   endtask

   initial begin
      int exp3 [5] = '{0, 1, 2, 3, 0};
      int exp4 [5] = '{1, 1, 1, 1, 3};

      tbl[0] = '{1'b1, 4'b0100, 32'h00A5_0000, 1,  4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1};
      tbl[1] = '{1'b1, 4'b0000, 32'h0,         11, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1};
      tbl[2] = '{1'b1, 4'b0000, 32'h0,         1,  4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
      tbl[3] = '{1'b1, 4'b0000, 32'h0,         2,  4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
      tbl[4] = '{1'b0, 4'b0001, 32'h0000_003C, 3,  4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
      tbl[5] = '{1'b1, 4'b0001, 32'h0000_003C, 1,  4'b0001, 1'b1, 8'h3C, 2'd0, 1'b1};

      // Power-on reset values
      model_reset();
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         check("reset_state", {15'd0, ack_o[k], start_o[k], data_o[k], gid_o[k], gv_o[k], tmo_o[k]}, 32'd0);
      rst_n = 1'b1;

      // Single byte to requester 2, then clken gating, then requester 0
      for (int v = 0; v < 6; v++) begin
         clken = tbl[v].ce; req = tbl[v].r; req_data = tbl[v].d;
         for (int j = 0; j < tbl[v].n; j++) begin
            step_cycle();
            check("vector", {19'd0, ack_o[0], start_o[0], data_o[0], gid_o[0], gv_o[0]},
                  {19'd0, tbl[v].e_ack, tbl[v].e_st, tbl[v].e_data, tbl[v].e_gid, tbl[v].e_gv});
         end
      end
      drain(20);

      // Asynchronous reset in the middle of a transfer
      req = 4'b0100; req_data = 32'h00A5_0000;
      repeat (3) step_cycle();
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++)
         check("async_reset", {15'd0, ack_o[k], start_o[k], data_o[k], gid_o[k], gv_o[k], tmo_o[k]}, 32'd0);
      model_reset();
      req = '0;
      @(negedge clk);
      rst_n = 1'b1; req = 4'b0001; req_data = 32'h1122_3344;
      step_cycle();
      check("ack_after_reset", {28'd0, ack_o[0]}, 32'b0001);
      drain(20);

      // Full round robin with single-byte grants
      apply_reset();
      req = 4'b1111; req_data = 32'hD4C3_B2A1;
      gq0.delete();
      for (int i = 0; i < 300 && gq0.size() < 5; i++) step_cycle();
      check("rr_count", gq0.size(), 5);
      for (int i = 0; i < 5 && i < gq0.size(); i++) check("rr_seq", gq0[i], exp3[i]);
      drain(20);

      // Bursts of four to requester 1, then requester 3
      apply_reset();
      req = 4'b1010; req_data = 32'h7766_5544;
      gq1.delete();
      for (int i = 0; i < 400 && gq1.size() < 5; i++) step_cycle();
      check("burst_count", gq1.size(), 5);
      for (int i = 0; i < 5 && i < gq1.size(); i++) check("burst_seq", gq1[i], exp4[i]);
      drain(20);

      // Transmitter never starts: timeout, then the failed requester is skipped
      apply_reset();
      tx_dead = 1'b1; req = 4'b0011; req_data = 32'h0000_BBAA;
      gq0.delete(); tmo_dq.delete();
      for (int i = 0; i < 100 && gq0.size() < 2; i++) step_cycle();
      check("tmo_seen", tmo_dq.size() > 0, 1);
      if (tmo_dq.size() > 0) check("tmo_delay", tmo_dq[0], TMO);
      check("tmo_starts", gq0.size(), 2);
      if (gq0.size() >= 2) begin
         check("tmo_first", gq0[0], 0);
         check("tmo_skip", gq0[1], 1);
      end
      tx_dead = 1'b0;
      drain(40);

      // Round robin with clken one clk in four
      apply_reset();
      req = 4'b1111; req_data = 32'hD4C3_B2A1;
      gq0.delete(); wq0.delete();
      for (int i = 0; i < 1500 && gq0.size() < 5; i++) begin
         clken = (i % 4 == 0);
         step_cycle();
      end
      check("slow_count", gq0.size(), 5);
      for (int i = 0; i < 5 && i < gq0.size(); i++) check("slow_seq", gq0[i], exp3[i]);
      check("slow_widths", wq0.size() >= 4, 1);
      for (int i = 0; i < wq0.size(); i++) check("slow_width", wq0[i], 4);
      drain(60);

      // Randomized traffic against the reference model
      apply_reset();
      for (int i = 0; i < 4000; i++) begin
         clken = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) req = N'($urandom);
         if ($urandom_range(0, 7) == 0) req_data = $urandom;
         if ($urandom_range(0, 299) == 0) tx_dead = ~tx_dead;
         if (i == 2000) begin
            #2 rst_n = 1'b0;
            #1;
            check("rand_reset", {26'd0, start_o[0], start_o[1], gv_o[0], gv_o[1], tmo_o[0], tmo_o[1]}, 32'd0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
         step_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
